// File: rtl/axis_cfg_lite_pkg.sv
// Shared constants for the AXI-Lite config slave:
// response codes, word-index slicing and write FSM states.
package axis_cfg_lite_pkg;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam int IDX_LSB = 2;

  typedef logic [1:0] wstate_t;

  localparam wstate_t W_IDLE   = 2'd0;
  localparam wstate_t W_COMMIT = 2'd1;
  localparam wstate_t W_RESP   = 2'd2;

endpackage

// File: rtl/axis_cfg_regfile.sv
// Shadow copy of every config word: one byte-merging
// write port and one registered read port.
module axis_cfg_regfile
  import axis_cfg_lite_pkg::*;
#(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [DW/8-1:0] wstrb_i,
  output logic [DW-1:0] merge_o,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  localparam int NW = 1 << AW;
  localparam int NB = DW / 8;

  logic [DW-1:0] mem_q [NW];
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] merge;

  // Unstrobed bytes keep the current shadow contents.
  always_comb begin
    merge = mem_q[waddr_i];
    for (int b = 0; b < NB; b++) begin
      if (wstrb_i[b]) merge[b*8 +: 8] = wdata_i[b*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NW; i++) mem_q[i] <= '0;
      rdata_q <= '0;
    end else begin
      if (we_i) mem_q[waddr_i] <= merge;
      if (re_i) rdata_q <= mem_q[raddr_i];
    end
  end

  assign merge_o = merge;
  assign rdata_o = rdata_q;

endmodule

// File: rtl/axis_cfg_lite.sv
// AXI4-Lite slave emitting single-cycle config beats,
// with shadow read-back and one live status word.
module axis_cfg_lite
  import axis_cfg_lite_pkg::*;
#(
  parameter int CONFIG_AWIDTH  = 5,
  parameter int CONFIG_DWIDTH  = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int STATUS_ADDR    = 31
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [AXI_ADDR_WIDTH-1:0]  axi_awaddr,
  input  logic                       axi_awvalid,
  output logic                       axi_awready,
  input  logic [CONFIG_DWIDTH-1:0]   axi_wdata,
  input  logic [CONFIG_DWIDTH/8-1:0] axi_wstrb,
  input  logic                       axi_wvalid,
  output logic                       axi_wready,
  output logic [1:0]                 axi_bresp,
  output logic                       axi_bvalid,
  input  logic                       axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]  axi_araddr,
  input  logic                       axi_arvalid,
  output logic                       axi_arready,
  output logic [CONFIG_DWIDTH-1:0]   axi_rdata,
  output logic [1:0]                 axi_rresp,
  output logic                       axi_rvalid,
  input  logic                       axi_rready,
  input  logic [CONFIG_DWIDTH-1:0]   status,
  output logic [CONFIG_AWIDTH-1:0]   cfg_addr,
  output logic [CONFIG_DWIDTH-1:0]   cfg_data,
  output logic                       cfg_valid
);

  localparam int AW = CONFIG_AWIDTH;
  localparam int DW = CONFIG_DWIDTH;
  localparam int SW = DW / 8;
  localparam logic [AW-1:0] STATUS_IDX = AW'(STATUS_ADDR);

  wstate_t       state_q, state_d;
  logic          aw_got_q, aw_got_d;
  logic          w_got_q, w_got_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [SW-1:0] wstrb_q, wstrb_d;
  logic [AW-1:0] cfg_addr_q, cfg_addr_d;
  logic [DW-1:0] cfg_data_q, cfg_data_d;

  logic          rvalid_q;
  logic          sel_q;
  logic [DW-1:0] status_q;

  logic          aw_hs, w_hs, ar_hs, r_hs;
  logic          commit;
  logic [AW-1:0] ar_idx;
  logic [DW-1:0] merged;
  logic [DW-1:0] rf_rdata;
  logic          unused_ok;

  assign commit      = (state_q == W_COMMIT);
  assign axi_awready = (state_q == W_IDLE) & ~aw_got_q;
  assign axi_wready  = (state_q == W_IDLE) & ~w_got_q;
  assign aw_hs       = axi_awvalid & axi_awready;
  assign w_hs        = axi_wvalid & axi_wready;
  assign ar_idx      = axi_araddr[AW+1:IDX_LSB];

  always_comb begin
    state_d    = state_q;
    aw_got_d   = aw_got_q;
    w_got_d    = w_got_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    cfg_addr_d = cfg_addr_q;
    cfg_data_d = cfg_data_q;
    unique case (state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_got_d = 1'b1;
          idx_d    = axi_awaddr[AW+1:IDX_LSB];
        end
        if (w_hs) begin
          w_got_d = 1'b1;
          wdata_d = axi_wdata;
          wstrb_d = axi_wstrb;
        end
        if ((aw_got_q | aw_hs) & (w_got_q | w_hs))
          state_d = W_COMMIT;
      end
      W_COMMIT: begin
        state_d    = W_RESP;
        aw_got_d   = 1'b0;
        w_got_d    = 1'b0;
        cfg_addr_d = idx_q;
        cfg_data_d = merged;
      end
      W_RESP: begin
        if (axi_bready) state_d = W_IDLE;
      end
      default: state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= W_IDLE;
      aw_got_q   <= 1'b0;
      w_got_q    <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      cfg_addr_q <= '0;
      cfg_data_q <= '0;
    end else begin
      state_q    <= state_d;
      aw_got_q   <= aw_got_d;
      w_got_q    <= w_got_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      cfg_addr_q <= cfg_addr_d;
      cfg_data_q <= cfg_data_d;
    end
  end

  // Beat fields are live during commit, then held in the _q copies.
  assign cfg_valid  = commit;
  assign cfg_addr   = commit ? idx_q : cfg_addr_q;
  assign cfg_data   = commit ? merged : cfg_data_q;
  assign axi_bvalid = (state_q == W_RESP);
  assign axi_bresp  = RESP_OKAY;

  assign axi_arready = ~rvalid_q;
  assign ar_hs       = axi_arvalid & ~rvalid_q;
  assign r_hs        = rvalid_q & axi_rready;

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      sel_q    <= 1'b0;
      status_q <= '0;
    end else begin
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        sel_q    <= (ar_idx == STATUS_IDX);
        status_q <= status;
      end else if (r_hs) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign axi_rvalid = rvalid_q;
  assign axi_rresp  = RESP_OKAY;
  assign axi_rdata  = sel_q ? status_q : rf_rdata;

  axis_cfg_regfile #(
    .AW (AW),
    .DW (DW)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we_i    (commit),
    .waddr_i (idx_q),
    .wdata_i (wdata_q),
    .wstrb_i (wstrb_q),
    .merge_o (merged),
    .re_i    (ar_hs),
    .raddr_i (ar_idx),
    .rdata_o (rf_rdata)
  );

  assign unused_ok = ^{axi_awaddr[AXI_ADDR_WIDTH-1:AW+2],
                       axi_awaddr[1:0],
                       axi_araddr[AXI_ADDR_WIDTH-1:AW+2],
                       axi_araddr[1:0]};

endmodule

// File: tb/tb_axis_cfg_lite.sv
// Directed bench for axis_cfg_lite against a shadow-array
// model with an expected-beat queue.
module tb_axis_cfg_lite;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] axi_awaddr;
  logic        axi_awvalid;
  logic        axi_awready;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_wvalid;
  logic        axi_wready;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid;
  logic        axi_bready;
  logic [31:0] axi_araddr;
  logic        axi_arvalid;
  logic        axi_arready;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rvalid;
  logic        axi_rready;
  logic [31:0] status;
  logic [4:0]  cfg_addr;
  logic [31:0] cfg_data;
  logic        cfg_valid;

  axis_cfg_lite dut (
    .clk         (clk),
    .rst         (rst),
    .axi_awaddr  (axi_awaddr),
    .axi_awvalid (axi_awvalid),
    .axi_awready (axi_awready),
    .axi_wdata   (axi_wdata),
    .axi_wstrb   (axi_wstrb),
    .axi_wvalid  (axi_wvalid),
    .axi_wready  (axi_wready),
    .axi_bresp   (axi_bresp),
    .axi_bvalid  (axi_bvalid),
    .axi_bready  (axi_bready),
    .axi_araddr  (axi_araddr),
    .axi_arvalid (axi_arvalid),
    .axi_arready (axi_arready),
    .axi_rdata   (axi_rdata),
    .axi_rresp   (axi_rresp),
    .axi_rvalid  (axi_rvalid),
    .axi_rready  (axi_rready),
    .status      (status),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .cfg_valid   (cfg_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    int          c;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] shadow [32];
  logic        prev_v = 1'b0;

  function automatic void chk(string name, logic [31:0] act,
                              logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old,
                                        logic [31:0] nw,
                                        logic [3:0]  s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_rd(logic [31:0] a);
    logic [4:0] i;
    i = a[6:2];
    return (i == 5'd31) ? status : shadow[i];
  endfunction

  // Per-cycle checker of beats and protocol invariants.
  always @(negedge clk) begin
    if (rst) begin
      prev_v <= 1'b0;
    end else begin
      chk("arready_vs_rvalid", axi_arready, !axi_rvalid);
      if (axi_bvalid) chk("bresp", axi_bresp, 0);
      if (axi_rvalid) chk("rresp", axi_rresp, 0);
      if (cfg_valid) begin
        chk("cfg_gap", prev_v, 0);
        if (exp_q.size() == 0) begin
          chk("cfg_extra", cfg_valid, 0);
        end else begin
          chk("cfg_addr", cfg_addr, exp_q[0].a);
          chk("cfg_data", cfg_data, exp_q[0].d);
          chk("cfg_cycle", cyc, exp_q[0].c);
          void'(exp_q.pop_front());
        end
      end else if (exp_q.size() != 0 && exp_q[0].c < cyc) begin
        chk("cfg_missing", cfg_valid, 1);
        void'(exp_q.pop_front());
      end
      prev_v <= cfg_valid;
    end
  end

  task automatic wait_hs(input int ch, output int hs);
    hs = -1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if ((ch == 0 && axi_awready) || (ch == 1 && axi_wready) ||
          (ch == 2 && axi_arready)) begin
        hs = cyc;
        break;
      end
    end
    if (hs < 0) begin
      vectors++;
      miscompares++;
      $display("FAIL hs_timeout ch=%0d", ch);
    end
    @(posedge clk);
    #1;
    case (ch)
      0: axi_awvalid = 1'b0;
      1: axi_wvalid = 1'b0;
      default: axi_arvalid = 1'b0;
    endcase
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int lag,
                           input int bhold, input bit pend,
                           input logic [31:0] paddr,
                           input logic [31:0] pdata);
    int hs_aw, hs_w, last;
    logic [4:0] i;
    logic [31:0] e;
    bit found;
    i = addr[6:2];
    e = merge(shadow[i], data, strb);
    shadow[i] = e;
    fork
      begin
        repeat (lag < 0 ? -lag : 0) begin @(posedge clk); #1; end
        axi_awaddr = addr;
        axi_awvalid = 1'b1;
        wait_hs(0, hs_aw);
      end
      begin
        repeat (lag > 0 ? lag : 0) begin @(posedge clk); #1; end
        axi_wdata = data;
        axi_wstrb = strb;
        axi_wvalid = 1'b1;
        wait_hs(1, hs_w);
      end
    join
    last = (hs_aw > hs_w) ? hs_aw : hs_w;
    exp_q.push_back('{a: i, d: e, c: last + 1});
    found = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (axi_bvalid) begin
        found = 1'b1;
        break;
      end
    end
    chk("b_seen", axi_bvalid, 1);
    if (found) chk("b_latency", cyc, last + 2);
    if (pend) begin
      axi_awaddr = paddr;
      axi_awvalid = 1'b1;
      axi_wdata = pdata;
      axi_wstrb = 4'hF;
      axi_wvalid = 1'b1;
    end
    for (int k = 0; k < bhold; k++) begin
      @(negedge clk);
      chk("b_hold", axi_bvalid, 1);
      chk("aw_blocked", axi_awready, 0);
      chk("w_blocked", axi_wready, 0);
    end
    axi_bready = 1'b1;
    @(posedge clk);
    #1;
    axi_bready = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data,
                    input logic [3:0] strb, input int lag);
    axi_write(addr, data, strb, lag, 0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp,
                          input int hold, output logic [31:0] got);
    int hs;
    axi_araddr = addr;
    axi_arvalid = 1'b1;
    wait_hs(2, hs);
    @(negedge clk);
    chk("r_latency", axi_rvalid, 1);
    chk("rdata", axi_rdata, exp);
    got = axi_rdata;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("r_hold", axi_rvalid, 1);
      chk("rdata_hold", axi_rdata, exp);
      chk("ar_blocked", axi_arready, 0);
    end
    axi_rready = 1'b1;
    @(posedge clk);
    #1;
    axi_rready = 1'b0;
    @(negedge clk);
    chk("ar_reready", axi_arready, 1);
    chk("r_dropped", axi_rvalid, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    chk("rst_awready", axi_awready, 1);
    chk("rst_wready", axi_wready, 1);
    chk("rst_arready", axi_arready, 1);
    chk("rst_bvalid", axi_bvalid, 0);
    chk("rst_rvalid", axi_rvalid, 0);
    chk("rst_cfg_valid", cfg_valid, 0);
    chk("rst_cfg_addr", cfg_addr, 0);
    chk("rst_cfg_data", cfg_data, 0);
    chk("rst_rdata", axi_rdata, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    logic [31:0] old;
    int hs;
    for (int k = 0; k < 32; k++) shadow[k] = '0;
    rst = 1'b1;
    axi_awaddr = '0; axi_awvalid = 1'b0;
    axi_wdata = '0; axi_wstrb = '0; axi_wvalid = 1'b0;
    axi_bready = 1'b0;
    axi_araddr = '0; axi_arvalid = 1'b0; axi_rready = 1'b0;
    status = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1;

    // AW first, W three cycles later.
    wr(32'h5C, 32'hDEADBEEF, 4'hF, 3);
    chk("pin_addr23", cfg_addr, 23);
    chk("pin_deadbeef", cfg_data, 32'hDEADBEEF);

    // W before AW, then both together.
    wr(32'h60, 32'h0000A5A5, 4'hF, -2);
    chk("pin_addr24a", cfg_addr, 24);
    wr(32'h60, 32'h12340000, 4'hC, 0);
    chk("pin_addr24b", cfg_addr, 24);
    chk("pin_merge24", cfg_data, 32'h1234A5A5);

    // Partial-strobe merge and read-back.
    wr(32'h10, 32'h11223344, 4'hF, 0);
    wr(32'h10, 32'hAABBCCDD, 4'h5, 1);
    chk("pin_merge", cfg_data, 32'h11BB33DD);
    axi_read(32'h10, model_rd(32'h10), 0, got);
    chk("pin_readback", got, 32'h11BB33DD);

    // Zero strobe still beats with unchanged data.
    wr(32'h20, 32'hFFFFFFFF, 4'h0, 0);
    chk("pin_strb0_addr", cfg_addr, 8);
    chk("pin_strb0_data", cfg_data, 0);

    // bready held low with a second write pending.
    axi_write(32'h08, 32'h12345678, 4'hF, 1, 10, 1'b1,
              32'h0C, 32'h9ABCDEF0);
    wr(32'h0C, 32'h9ABCDEF0, 4'hF, 0);
    chk("pin_pend_addr", cfg_addr, 3);
    axi_read(32'h08, model_rd(32'h08), 2, got);
    chk("pin_rd08", got, 32'h12345678);

    // Status word readback, with a write to the same index.
    status = 32'h0000CAFE;
    wr(32'h7C, 32'h00000055, 4'hF, 0);
    chk("pin_status_beat", cfg_addr, 31);
    axi_read(32'h7C, model_rd(32'h7C), 5, got);
    chk("pin_status", got, 32'h0000CAFE);

    // Upper and lower address bits ignored.
    axi_read(32'h0001005F, model_rd(32'h5C), 0, got);
    chk("pin_alias", got, 32'hDEADBEEF);

    // Read during commit returns the pre-write value.
    wr(32'h30, 32'h00000001, 4'hF, 0);
    old = model_rd(32'h30);
    fork
      wr(32'h30, 32'h00000077, 4'hF, 0);
      begin
        @(posedge clk);
        #1;
        axi_read(32'h30, old, 0, got);
      end
    join
    chk("pin_prewrite", got, 32'h1);
    axi_read(32'h30, model_rd(32'h30), 0, got);
    chk("pin_postwrite", got, 32'h77);

    // Reset between AW and W: no beat, all state cleared.
    axi_awaddr = 32'h40;
    axi_awvalid = 1'b1;
    wait_hs(0, hs);
    rst = 1'b1;
    exp_q.delete();
    for (int k = 0; k < 32; k++) shadow[k] = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    repeat (3) @(negedge clk);
    chk("rst_no_beat", cfg_valid, 0);
    @(posedge clk);
    #1;
    axi_read(32'h5C, model_rd(32'h5C), 0, got);
    chk("pin_rst_shadow", got, 0);
    wr(32'h40, 32'h0BADF00D, 4'hF, 0);
    chk("pin_after_rst", cfg_data, 32'h0BADF00D);

    repeat (4) @(posedge clk);
    chk("beats_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
